// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_div_ctrl : run/stop and glitch-free ratio control for a clock divider
// Revision 1.0
// ----------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pend_div;
  logic             pend_valid;

  logic accept;
  logic cfg_ok;
  logic wrap;
  logic boundary;

  assign accept   = cfg_valid && cfg_ready;
  assign cfg_ok   = accept && (cfg_div != '0);
  assign wrap     = (cnt == div - CNT_W'(1));
  assign boundary = wrap && clk_out;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= CNT_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
    end else begin
      tick    <= 1'b0;
      cfg_err <= accept && (cfg_div == '0);
      // Ready drops on a good accept and stays low until one edge after the ratio lands.
      cfg_ready <= cfg_ok ? 1'b0 : !pend_valid;

      case (state)
        IDLE: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          if (pend_valid) begin
            div        <= pend_div;
            pend_valid <= 1'b0;
          end
          if (cfg_ok) begin
            div <= cfg_div;
          end
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        default: begin
          if (wrap) begin
            cnt     <= '0;
            clk_out <= !clk_out;
            tick    <= !clk_out;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end

          // New ratios only take effect on a falling edge so no runt pulse can appear.
          if (boundary && pend_valid) begin
            div        <= pend_div;
            pend_valid <= 1'b0;
          end
          if (cfg_ok) begin
            pend_div   <= cfg_div;
            pend_valid <= 1'b1;
          end

          if (en) begin
            state <= RUN;
          end else if ((state == STOPPING) && boundary) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= STOPPING;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
